// File: rtl/ifetch_unit.sv
// Instruction-fetch and PC-sequencing stage for the single-cycle MIPS core.
// Fetches one word per step over req/ack, presents it to the decoder and computes next PC.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        step_done,
    output logic        illegal,
    output logic        halted,
    output logic [31:0] retire_cnt
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        next_pc;
    logic signed [31:0] br_off;
    logic               fetch_ok;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: op_supported = 1'b1;
            default:                                               op_supported = 1'b0;
        endcase
    endfunction

    assign opcode    = instr[31:26];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign fetch_ok  = op_supported(imem_rdata[31:26]);

    // Jump wins over a taken branch; all arithmetic wraps modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && zero)
            next_pc = pc_plus4 + $unsigned(br_off);
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nxt = fetch_ok ? EXEC : HALT;
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (step_done)
                    state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= PC_INIT;
            instr      <= 32'd0;
            illegal    <= 1'b0;
            halted     <= 1'b0;
            retire_cnt <= 32'd0;
        end else begin
            if (state == FETCH && imem_ack) begin
                instr <= imem_rdata;
                if (!fetch_ok) begin
                    illegal <= 1'b1;
                    halted  <= 1'b1;
                end
            end
            if (state == EXEC && step_done) begin
                pc         <= next_pc;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: table of fetch/step vectors plus reset, halt and jump corner cases.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, rst_n2;
    logic        imem_ack, imem_ack2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        branch, jump, zero;
    logic        step_done, step_done2;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] instr, instr2;
    logic [5:0]  opcode, opcode2;
    logic        instr_valid, instr_valid2;
    logic [31:0] pc, pc2, pc_plus4, pc_plus42;
    logic        illegal, illegal2, halted, halted2;
    logic [31:0] retire_cnt, retire_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .branch(branch),
        .jump(jump), .zero(zero), .step_done(step_done), .illegal(illegal),
        .halted(halted), .retire_cnt(retire_cnt)
    );

    // Second instance starts in the upper address region, with low bits set to be masked off.
    ifetch_unit #(.RESET_PC(32'h4000_000B)) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .instr(instr2), .opcode(opcode2),
        .instr_valid(instr_valid2), .pc(pc2), .pc_plus4(pc_plus42), .branch(branch),
        .jump(jump), .zero(zero), .step_done(step_done2), .illegal(illegal2),
        .halted(halted2), .retire_cnt(retire_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          lat;
        logic        br;
        logic        jp;
        logic        zr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr;
        int          waited;

        vecs[0] = '{32'h8C01_0004, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
        vecs[1] = '{32'h0000_0020, 3, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
        vecs[2] = '{32'hAC01_0000, 1, 1'b0, 1'b0, 1'b0, 32'h0000_000C};
        vecs[3] = '{32'h0000_0000, 2, 1'b0, 1'b0, 1'b1, 32'h0000_0010};
        vecs[4] = '{32'h1022_FFFF, 1, 1'b1, 1'b0, 1'b1, 32'h0000_0010};
        vecs[5] = '{32'h1022_FFFF, 1, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
        vecs[6] = '{32'h1000_FFF9, 1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};
        vecs[7] = '{32'h0000_0020, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[8] = '{32'h0800_0100, 1, 1'b1, 1'b1, 1'b1, 32'h0000_0400};

        rst_n = 1'b0; rst_n2 = 1'b0;
        imem_ack = 1'b0; imem_ack2 = 1'b0;
        imem_rdata = 32'd0; imem_rdata2 = 32'd0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0;
        step_done = 1'b0; step_done2 = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_flags", {30'd0, illegal, halted}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_pc2_masked", pc2, 32'h4000_0008);

        rst_n = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);

        exp_addr = 32'd0;
        for (int i = 0; i < 9; i++) begin
            waited = 0;
            while (!imem_req && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            chk($sformatf("v%0d_wait", i), waited, (i == 0) ? 32'd1 : 32'd0);
            for (int k = 0; k < vecs[i].lat; k++) begin
                chk($sformatf("v%0d_req%0d", i, k), {31'd0, imem_req}, 32'd1);
                chk($sformatf("v%0d_addr%0d", i, k), imem_addr, exp_addr);
                if (k == vecs[i].lat - 1) begin
                    imem_ack = 1'b1;
                    imem_rdata = vecs[i].word;
                end
                @(negedge clk);
            end
            imem_ack = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            chk($sformatf("v%0d_req_off", i), {31'd0, imem_req}, 32'd0);
            chk($sformatf("v%0d_opcode", i), {26'd0, opcode}, {26'd0, vecs[i].word[31:26]});
            chk($sformatf("v%0d_pc4", i), pc_plus4, exp_addr + 32'd4);
            branch = vecs[i].br; jump = vecs[i].jp; zero = vecs[i].zr;
            step_done = 1'b1;
            @(negedge clk);
            step_done = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_retire", i), retire_cnt, i + 1);
            exp_addr = vecs[i].exp_pc;
        end

        // Jump from the upper region keeps pc_plus4[31:28] and beats a taken branch.
        rst_n2 = 1'b1;
        @(negedge clk);
        chk("j2_req", {31'd0, imem_req2}, 32'd1);
        chk("j2_addr", imem_addr2, 32'h4000_0008);
        imem_ack2 = 1'b1; imem_rdata2 = 32'h0800_0100;
        @(negedge clk);
        imem_ack2 = 1'b0;
        chk("j2_valid", {31'd0, instr_valid2}, 32'd1);
        jump = 1'b1; branch = 1'b1; zero = 1'b1; step_done2 = 1'b1;
        @(negedge clk);
        step_done2 = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        chk("j2_pc", pc2, 32'h4000_0400);
        chk("j2_retire", retire_cnt2, 32'd1);

        // Unsupported opcode halts; nothing after it is requested or retired.
        chk("ill_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("ill_flags", {30'd0, illegal, halted}, 32'd3);
        chk("ill_instr", instr, 32'h2001_0005);
        for (int k = 0; k < 4; k++) begin
            step_done = 1'b1; imem_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("halt_req%0d", k), {30'd0, imem_req, instr_valid}, 32'd0);
        end
        step_done = 1'b0; imem_ack = 1'b0;
        chk("halt_retire", retire_cnt, 32'd9);
        chk("halt_pc", pc, 32'h0000_0400);

        // Reset during FETCH, stray ack in IDLE, then a fresh fetch at RESET_PC.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rf_req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rf_req_async", {31'd0, imem_req}, 32'd0);
        chk("rf_flags", {30'd0, illegal, halted}, 32'd0);
        chk("rf_retire", retire_cnt, 32'd0);
        chk("rf_pc", pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rf_refetch_req", {31'd0, imem_req}, 32'd1);
        chk("rf_refetch_addr", imem_addr, 32'd0);
        chk("rf_stray_ignored", instr, 32'd0);
        chk("rf_not_halted", {31'd0, halted}, 32'd0);

        // Reset during EXEC drops the instruction without counting it.
        imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("re_valid", {31'd0, instr_valid}, 32'd1);
        step_done = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("re_valid_off", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        step_done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("re_retire", retire_cnt, 32'd0);
        chk("re_pc", pc, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch and PC-sequencing stage that sits directly upstream of the main control decoder in the single-cycle MIPS core.
- Holds the PC and fetches one instruction per step from instruction memory over a req/ack handshake.
- Presents the latched instruction and its 6-bit opcode field to the decoder.
- Computes the next PC from the decoder's Branch/Jump outputs and the ALU Zero flag.
- Halts on any opcode outside the supported set {R-type, lw, sw, beq, j}.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  32  fetch address; equals pc, stable while imem_req=1
imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction
opcode  out  6  instr[31:26], to the decoder OPCode input
instr_valid  out  1  instr/opcode valid; datapath executes only while high
pc  out  32  address of the current instruction
pc_plus4  out  32  pc + 4
branch  in  1  decoder Branch
jump  in  1  decoder Jump
zero  in  1  ALU Zero
step_done  in  1  datapath commits the current instruction this cycle
illegal  out  1  unsupported opcode fetched (sticky)
halted  out  1  fetch stopped (sticky)
retire_cnt  out  32  committed-instruction count

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, pc=RESET_PC & ~3, instr=0.
  - instr_valid=0, imem_req=0, illegal=0, halted=0, retire_cnt=0.
  - All outputs change immediately on reset assertion, without waiting for a clock edge.
- opcode=instr[31:26] and pc_plus4=pc+4 are combinational from registers.
- imem_addr=pc.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: always advance to FETCH on the next edge; imem_req=0.
  - FETCH:
    - imem_req=1.
    - On an edge with imem_ack=1: instr<=imem_rdata. If imem_rdata[31:26] is in {000000, 100011, 101011, 000100, 000010}, go to EXEC. Otherwise set illegal=1 and halted=1, and go to HALT.
    - Without ack: stay in FETCH, with req and addr unchanged.
  - EXEC:
    - instr_valid=1, imem_req=0.
    - On step_done=1: pc<=next_pc, retire_cnt<=retire_cnt+1 (wraps at 2^32), go to FETCH.
    - Otherwise hold.
  - HALT: terminal until reset; instr_valid=0, imem_req=0. The illegal instruction stays in instr for debug.
- next_pc, priority order:
  1. jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}
  2. else branch=1 and zero=1 -> pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
  3. else pc_plus4
- All PC arithmetic is 32-bit modulo; pc=FFFF_FFFC sequential gives 0000_0000.
- imem_ack is ignored outside FETCH. step_done is ignored outside EXEC.
- Minimum throughput is 2 cycles per instruction: ack in the first FETCH cycle, then step_done in the first EXEC cycle.
- Reset mid-fetch: imem_req drops asynchronously. A late ack after reset release lands in IDLE and is ignored; FETCH then reissues the request at RESET_PC.
- Reset mid-EXEC: the instruction is discarded and not counted.

Test Plan:
1. Reset release, memory acks on the first FETCH cycle with 0x8C01_0004 (lw) -> IDLE→FETCH after 1 edge; imem_addr=0; instr_valid=1 the following cycle; opcode=100011.
2. Ack latency of 3 cycles, then step_done with branch=0, jump=0 -> imem_req high for exactly 3 cycles at addr 0; pc becomes 4; retire_cnt=1.
3. Take pc=0x0000_0010 with instr=0x1022_FFFF (beq, imm=-1), branch=1, zero=1, then step_done -> next pc=0x0000_0010. Repeat with zero=0 -> pc=0x0000_0014.
4. Take pc=0x4000_0008 with instr=0x0800_0100 (j), jump=1, branch=1, zero=1, then step_done -> pc=0x4000_0400 (jump has priority).
5. Fetch returns 0x2001_0005 (addi, opcode 001000) -> illegal=1, halted=1, HALT entered; no further imem_req; step_done pulses leave retire_cnt unchanged.
6. Assert rst_n=0 while in FETCH with imem_req=1, release, then pulse imem_ack in IDLE -> imem_req=0 immediately on reset; the stray ack is ignored; a new FETCH starts at RESET_PC; retire_cnt=0.
